// File: rtl/prbs_if.sv
// prbs_if: serial PRBS stream into the checker and lock/error status back out.
// Ports (modports):
//   master - drives d, d_valid; observes locked, err_pulse, err_count
//   slave  - receives d, d_valid; drives locked, err_pulse, err_count
interface prbs_if #(
  parameter int CNT_W = 16
);
  logic             d;
  logic             d_valid;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  modport master (output d, d_valid, input locked, err_pulse, err_count);
  modport slave  (input d, d_valid, output locked, err_pulse, err_count);
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS bit-error checker with lock FSM and error counter.
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset
//   bus - prbs_if.slave: d/d_valid in; locked, err_pulse, err_count out
// Build option: PRBS_CHECKER_ERRCNT_EN enables the saturating error counter;
//   when undefined err_count is tied to zero and no counter flops exist.
module prbs_checker #(
  parameter int                LENGTH     = 8,
  parameter logic [LENGTH-1:0] TAPS       = 'hB8,
  parameter int                LOCK_CNT   = 16,
  parameter int                UNLOCK_ERR = 4,
  parameter int                CNT_W      = 16
) (
  input logic   clk,
  input logic   rst,
  prbs_if.slave bus
);
  localparam int FW = $clog2(LENGTH);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(UNLOCK_ERR + 1);
  typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;
  state_t            state_q, state_d;
  logic [LENGTH-1:0] lfsr_q, lfsr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [MW-1:0]     match_q, match_d;
  logic [EW-1:0]     errs_q, errs_d;
  logic              locked_q, err_pulse_q, err_d;
  logic              pred, miss;
  assign pred = ^(lfsr_q & TAPS);
  assign miss = bus.d != pred;
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    fill_d  = fill_q;
    match_d = match_q;
    errs_d  = errs_q;
    err_d   = 1'b0;
    if (bus.d_valid) begin
      // once locked the register free-runs on its own prediction, so a single
      // corrupted input bit produces exactly one mismatch
      lfsr_d = {lfsr_q[LENGTH-2:0], state_q == LOCKED ? pred : bus.d};
      case (state_q)
        SEED: begin
          fill_d = fill_q + 1'b1;
          if (fill_q == FW'(LENGTH - 1)) begin
            state_d = CHECK;
            fill_d  = '0;
            match_d = '0;
          end
        end
        CHECK: begin
          if (miss || lfsr_q == '0) begin
            state_d = SEED;
            fill_d  = '0;
            match_d = '0;
          end else begin
            match_d = match_q + 1'b1;
            if (match_d == MW'(LOCK_CNT)) begin
              state_d = LOCKED;
              errs_d  = '0;
            end
          end
        end
        default: begin
          err_d  = miss;
          errs_d = miss ? errs_q + 1'b1 : '0;
          if (miss && errs_d == EW'(UNLOCK_ERR)) begin
            state_d = SEED;
            fill_d  = '0;
            match_d = '0;
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      lfsr_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      errs_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      errs_q      <= errs_d;
      locked_q    <= state_d == LOCKED;
      err_pulse_q <= err_d;
    end
  end
  assign bus.locked    = locked_q;
  assign bus.err_pulse = err_pulse_q;
`ifdef PRBS_CHECKER_ERRCNT_EN
  logic [CNT_W-1:0] err_count_q;
  always_ff @(posedge clk) begin
    if (rst) err_count_q <= '0;
    else if (err_d && !(&err_count_q)) err_count_q <= err_count_q + 1'b1;
  end
  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed-vector bench for prbs_checker (lock, errors, unlock, idle, reset).
module tb_prbs_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  prbs_if #(.CNT_W(3)) bus ();
  prbs_checker #(.CNT_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef PRBS_CHECKER_ERRCNT_EN
  localparam bit EC = 1'b1;
`else
  localparam bit EC = 1'b0;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] g;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic b);
    @(negedge clk);
    rst = r;
    bus.d_valid = v;
    bus.d = b;
    @(posedge clk);
    #1;
  endtask
  task automatic gen(output logic b);
    b = ^(g & 8'hB8);
    g = {g[6:0], b};
  endtask
  task automatic send(input int n, input logic inv = 1'b0);
    logic b;
    for (int i = 0; i < n; i++) begin
      gen(b);
      step(1'b0, 1'b1, b ^ inv);
    end
  endtask
  task automatic do_rst();
    step(1'b1, 1'b0, 1'b0);
    g = 8'h01;
  endtask
  task automatic lk(input string tag, input logic exp);
    chk(tag, 32'(bus.locked), 32'(exp));
  endtask
  task automatic pl(input string tag, input logic exp);
    chk(tag, 32'(bus.err_pulse), 32'(exp));
  endtask
  task automatic cnt(input string tag, input int n);
    chk(tag, 32'(bus.err_count), EC ? 32'(n) : 32'd0);
  endtask
  initial begin
    logic b;
    int seen;
    bus.d = 1'b0;
    bus.d_valid = 1'b0;
    do_rst();
    lk("rst_locked", 1'b0);
    pl("rst_pulse", 1'b0);
    cnt("rst_count", 0);
    send(23);
    lk("lock_bit23", 1'b0);
    send(1);
    lk("lock_bit24", 1'b1);
    send(16);
    lk("lock_bit40", 1'b1);
    cnt("count_clean", 0);
    send(10);
    send(1, 1'b1);
    pl("flip50_pulse", 1'b1);
    lk("flip50_locked", 1'b1);
    cnt("flip50_count", 1);
    send(1);
    pl("flip50_pulse_off", 1'b0);
    cnt("flip50_count_hold", 1);
    for (int i = 0; i < 4; i++) begin
      send(1, 1'b1);
      pl("burst_pulse", 1'b1);
      lk("burst_locked", i < 3);
    end
    cnt("burst_count", 5);
    send(1);
    pl("burst_pulse_off", 1'b0);
    lk("relock_early", 1'b0);
    send(22);
    lk("relock_bit23", 1'b0);
    send(1);
    lk("relock_bit24", 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(1, 1'b1);
      cnt("sat_count", (6 + i > 7) ? 7 : 6 + i);
      send(1);
    end
    lk("sat_locked", 1'b1);
    do_rst();
    cnt("rst2_count", 0);
    send(10);
    send(1, 1'b1);
    pl("check_err_pulse", 1'b0);
    cnt("check_err_count", 0);
    send(23);
    lk("check_relock23", 1'b0);
    send(1);
    lk("check_relock24", 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(1, 1'b1);
      send(1);
    end
    cnt("pre_rst_count", 3);
    lk("pre_rst_locked", 1'b1);
    gen(b);
    step(1'b1, 1'b1, ~b);
    lk("midrst_locked", 1'b0);
    pl("midrst_pulse", 1'b0);
    cnt("midrst_count", 0);
    do_rst();
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b0, 1'b1, 1'b0);
      seen |= int'(bus.locked);
    end
    chk("zeros_never_lock", 32'(seen), 32'd0);
    cnt("zeros_count", 0);
    do_rst();
    for (int i = 1; i <= 24; i++) begin
      gen(b);
      step(1'b0, 1'b1, b);
      if (i == 23) lk("toggle_lock23", 1'b0);
      step(1'b0, 1'b0, ~b);
      pl("toggle_idle_pulse", 1'b0);
      if (i == 23) lk("toggle_idle23", 1'b0);
    end
    lk("toggle_lock24", 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    pl("idle_locked_pulse", 1'b0);
    lk("idle_locked", 1'b1);
    send(1);
    pl("after_idle_pulse", 1'b0);
    lk("after_idle_locked", 1'b1);
    cnt("toggle_count", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
